// File: rtl/dctr7_pkg.sv
// dctr7_pkg: shared width constant and FSM state type for the dctr7 down-counter.
package dctr7_pkg;

    localparam int unsigned CTR_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dctr7_state_t;

endpackage

// File: rtl/dctr7_if.sv
// dctr7_if: load/enable inputs and count/status outputs of the dctr7 timer.
interface dctr7_if;
    import dctr7_pkg::*;

    logic [CTR_W-1:0] D;
    logic             LDL;
    logic             ENAB;
    logic [CTR_W-1:0] Q;
    logic [CTR_W-1:0] QL;
    logic             TC;
    logic             BUSY;

    modport master (
        output D, LDL, ENAB,
        input  Q, QL, TC, BUSY
    );

    modport slave (
        input  D, LDL, ENAB,
        output Q, QL, TC, BUSY
    );

endinterface

// File: rtl/dctr7_dctnr.sv
// dctnr: one count bit with load and borrow-enable; toggles when its borrow-in is high.
module dctnr (
    input  logic D,
    input  logic LD,
    input  logic LDL,
    input  logic ENAB,
    input  logic XCK,
    input  logic RESET,
    output logic Q,
    output logic QL
);

    logic q_q;

    // Bit state: reset, then load (either load strobe), then borrow toggle.
    always_ff @(posedge XCK) begin
        if (RESET) begin
            q_q <= 1'b0;
        end else if (LD || !LDL) begin
            q_q <= D;
        end else if (ENAB) begin
            q_q <= ~q_q;
        end
    end

    assign Q  = q_q;
    assign QL = ~q_q;

endmodule

// File: rtl/dctr7.sv
// dctr7: 7-bit loadable down-counter/timer with period register and terminal-count strobe.
// Optional feature: define DCTR7_AUTORELOAD_EN for periodic auto-reload; otherwise one-shot.
module dctr7
    import dctr7_pkg::*;
(
    input  logic   XCK,
    input  logic   RESET,
    dctr7_if.slave bus
);

    dctr7_state_t     state_q, state_d;
    logic [CTR_W-1:0] per_q;
    logic             tc_q;
    logic             busy_q;

    logic [CTR_W-1:0] q;
    logic [CTR_W-1:0] ql;
    logic [CTR_W-1:0] bw;
    logic [CTR_W-1:0] load_val;
    logic             enab_dec;
    logic             expiry;
    logic             reload;

    // Decode decrement/expiry and the next FSM state; a load always wins.
    always_comb begin
        enab_dec = 1'b0;
        expiry   = 1'b0;
        reload   = 1'b0;
        state_d  = state_q;
        load_val = bus.LDL ? per_q : bus.D;

        if (state_q == RUN && bus.ENAB && bus.LDL) begin
            if (q == '0) begin
                expiry = 1'b1;
            end else begin
                enab_dec = 1'b1;
            end
        end

        if (!bus.LDL) begin
            state_d = RUN;
        end else if (expiry) begin
`ifdef DCTR7_AUTORELOAD_EN
            reload  = 1'b1;
            state_d = RUN;
`else
            state_d = DONE;
`endif
        end
    end

    // Borrow chain: bit i toggles only when every lower bit is already 0.
    for (genvar i = 0; i < CTR_W; i++) begin : g_bit
        if (i == 0) begin : g_first
            assign bw[i] = enab_dec;
        end else begin : g_rest
            assign bw[i] = enab_dec & ~|q[i-1:0];
        end

        dctnr u_bit (
            .D     (load_val[i]),
            .LD    (reload),
            .LDL   (bus.LDL),
            .ENAB  (bw[i]),
            .XCK   (XCK),
            .RESET (RESET),
            .Q     (q[i]),
            .QL    (ql[i])
        );
    end

    // FSM, period register and registered status outputs.
    always_ff @(posedge XCK) begin
        if (RESET) begin
            state_q <= IDLE;
            per_q   <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= expiry;
            busy_q  <= (state_d == RUN);
            if (!bus.LDL) begin
                per_q <= bus.D;
            end
        end
    end

    assign bus.Q    = q;
    assign bus.QL   = ql;
    assign bus.TC   = tc_q;
    assign bus.BUSY = busy_q;

endmodule
